// File: rtl/bdcmotor_busif_if.sv
// Host-side 8-bit strobed parallel bus for the motor channel register block.
interface bdcmotor_busif_if;
    logic [2:0] addr;
    logic [7:0] datain;
    logic       wr;
    logic       rd;
    logic [7:0] dataout;

    modport master (output addr, output datain, output wr, output rd, input dataout);
    modport slave  (input addr, input datain, input wr, input rd, output dataout);
endinterface

// File: rtl/bdcmotor_busif.sv
// Register decode, clock-enable timebase and coherent tach snapshot for one motor channel.
// Optional duty-write watchdog brake is built when WATCHDOG_EN is defined.
module bdcmotor_busif #(
    parameter int FREEZE_TIMEOUT = 255,
    parameter int WDOG_CYCLES    = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    bdcmotor_busif_if.slave bus,
    input  logic [7:0] countl,
    input  logic [7:0] counth,
    input  logic       currentlimit,
    output logic [7:0] wrtdata,
    output logic       pwmldce,
    output logic       pwmcntce,
    output logic       filterce,
    output logic       freeze,
    output logic       invphase,
    output logic       invertpwm,
    output logic       enablepwm,
    output logic       run
);
    localparam int TW = (FREEZE_TIMEOUT < 2) ? 1 : $clog2(FREEZE_TIMEOUT + 1);

    logic [7:0]    wrtdata_q, wrtdata_d;
    logic          pwmldce_q, pwmldce_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [7:0]    pwmdiv_q, pwmdiv_d, filtdiv_q, filtdiv_d;
    logic [7:0]    pwmcnt_q, pwmcnt_d, filtcnt_q, filtcnt_d;
    logic          pwmce_q, pwmce_d, filtce_q, filtce_d;
    logic [15:0]   snap_q, snap_d;
    logic          freeze_q, freeze_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    dout_q, dout_d;
    logic          wd_trip;
    logic          wr_en, rd_en, duty_wr;

    // Write wins over a simultaneous read; the read is dropped entirely.
    assign wr_en   = bus.wr;
    assign rd_en   = bus.rd & ~bus.wr;
    assign duty_wr = wr_en && (bus.addr == 3'd0);

`ifdef WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_trip_q, wd_trip_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        wd_trip_d = wd_trip_q;
        if (duty_wr) begin
            wd_cnt_d  = '0;
            wd_trip_d = 1'b0;
        end else if (!wd_trip_q) begin
            if (wd_cnt_q == WW'(WDOG_CYCLES - 1)) wd_trip_d = 1'b1;
            else                                  wd_cnt_d  = wd_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_trip_q <= wd_trip_d;
        end
    end

    assign wd_trip = wd_trip_q;
`else
    assign wd_trip = 1'b0;
`endif

    always_comb begin
        wrtdata_d = wrtdata_q;
        pwmldce_d = 1'b0;
        ctrl_d    = ctrl_q;
        pwmdiv_d  = pwmdiv_q;
        filtdiv_d = filtdiv_q;
        snap_d    = snap_q;
        freeze_d  = freeze_q;
        tmo_d     = tmo_q;
        dout_d    = dout_q;
        sticky_d  = sticky_q | currentlimit;

        pwmce_d   = (pwmcnt_q == pwmdiv_q);
        pwmcnt_d  = pwmce_d ? 8'd0 : pwmcnt_q + 8'd1;
        filtce_d  = (filtcnt_q == filtdiv_q);
        filtcnt_d = filtce_d ? 8'd0 : filtcnt_q + 8'd1;

        // Auto-release so a host that never reads the high byte cannot stall the tach.
        if (freeze_q) begin
            if (tmo_q == TW'(FREEZE_TIMEOUT - 1)) begin
                freeze_d = 1'b0;
                tmo_d    = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (wr_en) begin
            case (bus.addr)
                3'd0: begin
                    wrtdata_d = bus.datain;
                    pwmldce_d = 1'b1;
                end
                3'd1: ctrl_d = bus.datain[3:0];
                3'd2: begin
                    pwmdiv_d = bus.datain;
                    pwmcnt_d = 8'd0;
                    pwmce_d  = 1'b0;
                end
                3'd3: begin
                    filtdiv_d = bus.datain;
                    filtcnt_d = 8'd0;
                    filtce_d  = 1'b0;
                end
                default: ;
            endcase
        end

        if (rd_en) begin
            case (bus.addr)
                3'd1: dout_d = {4'd0, ctrl_q};
                3'd2: dout_d = pwmdiv_q;
                3'd3: dout_d = filtdiv_q;
                3'd4: begin
                    snap_d   = {counth, countl};
                    dout_d   = countl;
                    freeze_d = 1'b1;
                    tmo_d    = '0;
                end
                3'd5: begin
                    dout_d   = snap_q[15:8];
                    freeze_d = 1'b0;
                    tmo_d    = '0;
                end
                3'd6: begin
                    dout_d   = {5'd0, wd_trip, sticky_q | currentlimit, freeze_q};
                    sticky_d = currentlimit;
                end
                default: dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrtdata_q <= '0;
            pwmldce_q <= 1'b0;
            ctrl_q    <= '0;
            pwmdiv_q  <= '0;
            filtdiv_q <= '0;
            pwmcnt_q  <= '0;
            filtcnt_q <= '0;
            pwmce_q   <= 1'b0;
            filtce_q  <= 1'b0;
            snap_q    <= '0;
            freeze_q  <= 1'b0;
            tmo_q     <= '0;
            sticky_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            wrtdata_q <= wrtdata_d;
            pwmldce_q <= pwmldce_d;
            ctrl_q    <= ctrl_d;
            pwmdiv_q  <= pwmdiv_d;
            filtdiv_q <= filtdiv_d;
            pwmcnt_q  <= pwmcnt_d;
            filtcnt_q <= filtcnt_d;
            pwmce_q   <= pwmce_d;
            filtce_q  <= filtce_d;
            snap_q    <= snap_d;
            freeze_q  <= freeze_d;
            tmo_q     <= tmo_d;
            sticky_q  <= sticky_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.dataout = dout_q;
    assign wrtdata     = wrtdata_q;
    assign pwmldce     = pwmldce_q;
    assign pwmcntce    = pwmce_q;
    assign filterce    = filtce_q;
    assign freeze      = freeze_q;
    assign invphase    = ctrl_q[0];
    assign invertpwm   = ctrl_q[1];
    assign enablepwm   = ctrl_q[2];
    // Watchdog brakes the channel without touching the stored ctrl bit.
    assign run         = ctrl_q[3] & ~wd_trip;
endmodule

// File: tb/tb_bdcmotor_busif.sv
// Directed self-checking bench for bdcmotor_busif (watchdog section built with WATCHDOG_EN).
module tb_bdcmotor_busif;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] countl, counth;
    logic       currentlimit;
    logic [7:0] wrtdata;
    logic       pwmldce, pwmcntce, filterce, freeze;
    logic       invphase, invertpwm, enablepwm, run;
    int         total = 0;
    int         bad   = 0;
    int         n;
    logic [7:0] pat;

`ifdef WATCHDOG_EN
    localparam logic [7:0] WD_BIT = 8'h04;
`else
    localparam logic [7:0] WD_BIT = 8'h00;
`endif

    bdcmotor_busif_if bus ();

    bdcmotor_busif #(.FREEZE_TIMEOUT(255), .WDOG_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .countl(countl), .counth(counth), .currentlimit(currentlimit),
        .wrtdata(wrtdata), .pwmldce(pwmldce), .pwmcntce(pwmcntce), .filterce(filterce),
        .freeze(freeze), .invphase(invphase), .invertpwm(invertpwm),
        .enablepwm(enablepwm), .run(run)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        bus.addr = a; bus.datain = d; bus.wr = 1'b1;
        cyc();
        bus.wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a);
        bus.addr = a; bus.rd = 1'b1;
        cyc();
        bus.rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; currentlimit = 1'b0; countl = 8'h00; counth = 8'h00;
        bus.addr = 3'd0; bus.datain = 8'h00; bus.wr = 1'b0; bus.rd = 1'b0;
        repeat (3) cyc();
        check("rst_outs", {8'h00, freeze, run, enablepwm, invphase, invertpwm, pwmldce, pwmcntce, filterce}, 16'h0000);
        check("rst_wrtdata", {8'h00, wrtdata}, 16'h0000);
        check("rst_dataout", {8'h00, bus.dataout}, 16'h0000);

        reset = 1'b0;
        cyc();
        check("ce_div0_a", {14'd0, pwmcntce, filterce}, 16'h0003);
        cyc();
        check("ce_div0_b", {14'd0, pwmcntce, filterce}, 16'h0003);

        // pwmdiv=3: pulse every 4th clock after the write
        wr_reg(3'd2, 8'h03);
        check("div_wr_ce", {15'd0, pwmcntce}, 16'h0000);
        for (int i = 0; i < 8; i++) begin cyc(); pat[i] = pwmcntce; end
        check("div3_pat", {8'h00, pat}, 16'h0088);
        check("filt_still", {15'd0, filterce}, 16'h0001);
        cyc(); cyc();
        wr_reg(3'd2, 8'h03);
        for (int i = 0; i < 8; i++) begin cyc(); pat[i] = pwmcntce; end
        check("div3_restart", {8'h00, pat}, 16'h0088);

        wr_reg(3'd0, 8'h80);
        check("duty_wrtdata", {8'h00, wrtdata}, 16'h0080);
        check("duty_ldce_hi", {15'd0, pwmldce}, 16'h0001);
        cyc();
        check("duty_ldce_lo", {15'd0, pwmldce}, 16'h0000);

        wr_reg(3'd1, 8'h0C);
        check("ctrl_bits", {12'd0, invphase, invertpwm, enablepwm, run}, 16'h0003);
        rd_reg(3'd2);
        check("rd_pwmdiv", {8'h00, bus.dataout}, 16'h0003);
        rd_reg(3'd7);
        check("rd_unmapped", {8'h00, bus.dataout}, 16'h0000);
        wr_reg(3'd5, 8'hAA);
        rd_reg(3'd5);
        check("ro_write_ign", {8'h00, bus.dataout}, 16'h0000);

        rd_reg(3'd1);
        check("rd_ctrl", {8'h00, bus.dataout}, 16'h000C);
        bus.addr = 3'd3; bus.datain = 8'h05; bus.wr = 1'b1; bus.rd = 1'b1;
        cyc();
        bus.wr = 1'b0; bus.rd = 1'b0;
        check("wr_rd_hold", {8'h00, bus.dataout}, 16'h000C);
        rd_reg(3'd3);
        check("wr_rd_wrote", {8'h00, bus.dataout}, 16'h0005);

        countl = 8'hFF; counth = 8'h12;
        rd_reg(3'd4);
        check("snap_lo", {8'h00, bus.dataout}, 16'h00FF);
        check("snap_frz", {15'd0, freeze}, 16'h0001);
        countl = 8'h00; counth = 8'h13;
        rd_reg(3'd5);
        check("snap_hi", {8'h00, bus.dataout}, 16'h0012);
        check("snap_unfrz", {15'd0, freeze}, 16'h0000);

        rd_reg(3'd4);
        check("tmo_lo", {8'h00, bus.dataout}, 16'h0000);
        n = 0;
        while (freeze === 1'b1 && n < 400) begin cyc(); n++; end
        check("tmo_clocks", 16'(n), 16'd255);
        rd_reg(3'd6);
        check("tmo_status", {8'h00, bus.dataout}, {8'h00, WD_BIT});
        check("run_after_wait", {15'd0, run}, {15'd0, (WD_BIT == 8'h00)});
        rd_reg(3'd5);
        check("stale_hi", {8'h00, bus.dataout}, 16'h0013);

        wr_reg(3'd0, 8'h40);
        check("run_restored", {15'd0, run}, 16'h0001);
        currentlimit = 1'b1; cyc(); currentlimit = 1'b0;
        rd_reg(3'd6);
        check("sticky_set", {8'h00, bus.dataout}, 16'h0002);
        rd_reg(3'd6);
        check("sticky_clr", {8'h00, bus.dataout}, 16'h0000);
        currentlimit = 1'b1;
        rd_reg(3'd6);
        currentlimit = 1'b0;
        check("sticky_same", {8'h00, bus.dataout}, 16'h0002);
        rd_reg(3'd6);
        check("sticky_kept", {8'h00, bus.dataout}, 16'h0002);
        rd_reg(3'd6);
        check("sticky_clr2", {8'h00, bus.dataout}, 16'h0000);

`ifdef WATCHDOG_EN
        wr_reg(3'd0, 8'h41);
        n = 0;
        while (run === 1'b1 && n < 200) begin cyc(); n++; end
        check("wd_clocks", 16'(n), 16'd100);
        rd_reg(3'd6);
        check("wd_status", {8'h00, bus.dataout}, 16'h0004);
        rd_reg(3'd1);
        check("wd_ctrl_kept", {8'h00, bus.dataout}, 16'h000C);
        wr_reg(3'd0, 8'h42);
        check("wd_run_back", {15'd0, run}, 16'h0001);
        rd_reg(3'd6);
        check("wd_status_clr", {8'h00, bus.dataout}, 16'h0000);
`endif

        // asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_outs", {8'h00, freeze, run, enablepwm, invphase, invertpwm, pwmldce, pwmcntce, filterce}, 16'h0000);
        check("arst_wrtdata", {8'h00, wrtdata}, 16'h0000);
        cyc();
        reset = 1'b0;
        cyc();
        check("arst_ce_a", {14'd0, pwmcntce, filterce}, 16'h0003);
        cyc();
        check("arst_ce_b", {14'd0, pwmcntce, filterce}, 16'h0003);
        rd_reg(3'd2);
        check("arst_pwmdiv", {8'h00, bus.dataout}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
